can_rx_frame_sequencer: RTL and testbench
=========================================

// Module: can_rx_frame_sequencer
// PURPOSE
// - Receive-side frame sequencer that owns the bit_unstuffing datapath.
// - Gates raw sampled bits into the destuffer only inside the stuffed region (SOF..last CRC bit) and holds it in reset elsewhere.
// - Walks the destuffed bit stream field by field (ID/IDE/RTR/DLC/DATA/CRC), then checks the fixed-form tail unstuffed.
// - Sits between bit timing (rx_bit/rx_valid) and the RX buffer/CRC checker.
// PARAMETERS
// - IDLE_BITS  11  consecutive recessive bits required for bus integration (IDLE->WAIT_SOF)
// - EOF_BITS   7   end-of-frame length
// - MAX_BYTES  8   data bytes captured; DLC>MAX_BYTES is clamped to MAX_BYTES
// PORTS
// - clk          in   1   system clock
// - rst_n        in   1   asynchronous, active-low reset
// - rx_bit       in   1   sampled bus bit (0 = dominant)
// - rx_valid     in   1   one-cycle strobe per bus bit
// - ds_rst       out  1   registered reset to the destuffer rst; high outside the stuffed region
// - ds_bit_in    out  1   = rx_bit (combinational)
// - ds_bit_valid out  1   rx_valid gated by stuffed-region / SOF logic (combinational)
// - ds_bit       in   1   destuffer bit_out
// - ds_valid     in   1   destuffer bit_out_valid (one cycle after ds_bit_valid)
// - ds_err       in   1   destuffer error_stuff
// - rx_id        out  29  identifier; standard ID in [28:18], zero-extended below
// - rx_ide/rx_rtr out 1   frame format / remote request
// - rx_dlc       out  4   raw DLC
// - rx_data      out  64  data, first received byte in [63:56], unused bytes 0
// - rx_crc       out  15  received CRC field
// - ack_slot     out  1   high for the whole ACK-slot bit time (drives TX ACK)
// - frame_ok     out  1   one-cycle pulse: EOF completed with no error
// - stuff_err    out  1   one-cycle pulse: ds_err forwarded
// - form_err     out  1   one-cycle pulse: fixed-form bit violated
// - overload     out  1   one-cycle pulse: dominant bit in intermission bit 1 or 2
// - busy         out  1   state not in {IDLE, WAIT_SOF}
// BEHAVIOUR
// - Reset: state=IDLE, ds_rst=1, all captured fields 0, all pulses 0, ack_slot=0, busy=0.
// - IDLE: count recessive rx bits; any dominant clears the count; IDLE_BITS recessive bits -> WAIT_SOF, ds_rst<=0.
// - WAIT_SOF: ds_bit_valid = rx_valid & ~rx_bit; a dominant bit -> SOF, clears all capture registers.
// - SOF: the first ds_valid (SOF echo) is consumed -> ID_A.
// - In stuffed states, fields advance only on ds_valid; ds_bit_valid = rx_valid.
//   - Field sequence: ID_A(11) -> RTR/SRR(1) -> IDE(1).
//   - IDE=0: -> R0 -> DLC(4).
//   - IDE=1: -> ID_B(18) -> RTR(1) -> R1 -> R0 -> DLC(4).
//   - After DLC: -> DATA(8*min(DLC,MAX_BYTES), 0 if RTR) -> CRC(15).
// - Raw run tracker on forwarded bits: run resets to 1 on a change, increments on an equal bit, and resets to 1 after the bit following run==5 (stuff bit).
// - After the 15th CRC bit: if run==5 -> STUFF_TAIL (forward exactly one more raw bit, wait its ds_valid/ds_err), else -> CRC_DEL.
// - Entering CRC_DEL: ds_rst<=1; ds_bit_valid=0.
//   - From here fields advance on rx_valid.
//   - CRC_DEL, ACK_DEL and EOF bits 1..EOF_BITS-1 must be recessive, else form_err.
//   - EOF last bit is ignored.
// - ACK_SLOT: ack_slot=1 from entry until the next rx_valid; the bit value is ignored.
// - After the last EOF bit: frame_ok pulse -> INTER (3 bits).
//   - Dominant in bit 1 or 2 -> overload, -> IDLE.
//   - Dominant in bit 3 -> treated as SOF (forward it, -> SOF).
//   - Three recessive bits -> WAIT_SOF.
// - Errors: ds_err or form_err -> pulse, ds_rst<=1, state -> IDLE (re-integrate).
//   - Captured fields hold their values.
//   - ds_err has priority over a ds_valid in the same cycle.
// - Field counter is 7 bits, cleared on each field entry; DATA length = {DLC clamp,3'b0}.
// - rst_n asserted mid-frame: immediate return to the reset state; no frame_ok.
// STRUCTURE
// - can_pkg: state localparams, field lengths (11,18,4,15), IDLE_BITS/EOF_BITS defaults.
// - Sub-module can_rx_run_tracker: raw same-bit run counter / stuff-bit predictor.
// TESTING
// - 11 recessive then std frame ID=0x123, DLC=2, data A5 3C -> frame_ok once, rx_id[28:18]=0x123, rx_data[63:48]=A53C.
// - Ext frame ID=0x1ABCDEF0, RTR=1, DLC=4 -> zero DATA bits consumed, rx_ide=1, rx_rtr=1, rx_data=0.
// - CRC ending in 5 equal bits plus stuff bit -> STUFF_TAIL taken, frame_ok; with a wrong tail bit -> stuff_err, IDLE.
// - Dominant CRC_DEL -> form_err, ds_rst=1, no frame_ok until 11 recessive + new frame.
// - Dominant in intermission bit 2 -> overload pulse; dominant in bit 3 -> next frame received back-to-back.
// - DLC=15 -> 64 data bits captured; rst_n pulsed mid-DATA -> all outputs at reset values.

Source files
------------

// File: rtl/can_pkg.sv
// Shared types and constants for the CAN receive frame sequencer.
package can_pkg;

  localparam int unsigned DefIdleBits = 11;
  localparam int unsigned DefEofBits  = 7;
  localparam int unsigned DefMaxBytes = 8;

  localparam int unsigned IdALen   = 11;
  localparam int unsigned IdBLen   = 18;
  localparam int unsigned DlcLen   = 4;
  localparam int unsigned CrcLen   = 15;
  localparam int unsigned StuffRun = 5;

  // Stuffed-region states are contiguous from StSof to StStuffTail.
  typedef enum logic [4:0] {
    StIdle, StWaitSof, StSof, StIdA, StSrr, StIde, StIdB, StRtr, StR1, StR0,
    StDlc, StData, StCrc, StStuffTail, StCrcDel, StAckSlot, StAckDel, StEof, StInter
  } rx_state_e;

  function automatic logic [3:0] dlc_clamp(input logic [3:0] dlc, input logic [3:0] max_bytes);
    return (dlc > max_bytes) ? max_bytes : dlc;
  endfunction

  function automatic logic [6:0] data_bits(input logic [3:0] bytes);
    return {bytes, 3'b000};
  endfunction

endpackage

// File: rtl/can_rx_run_tracker.sv
// Tracks the run of equal raw bits forwarded to the destuffer and flags when
// the next raw bit must be a stuff bit.
module can_rx_run_tracker
  import can_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic valid_i,
  input  logic bit_i,
  input  logic start_i,
  output logic stuff_next_o
);

  logic [2:0] run_q, run_d;
  logic       last_q, last_d;

  always_comb begin
    run_d  = run_q;
    last_d = last_q;
    if (valid_i) begin
      last_d = bit_i;
      // A bit following a full run is the stuff bit and starts a new run.
      if (start_i || (run_q == 3'(StuffRun)) || (bit_i != last_q)) begin
        run_d = 3'd1;
      end else begin
        run_d = run_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q  <= 3'd0;
      last_q <= 1'b1;
    end else begin
      run_q  <= run_d;
      last_q <= last_d;
    end
  end

  assign stuff_next_o = (run_q == 3'(StuffRun));

endmodule

// File: rtl/can_rx_frame_sequencer.sv
// CAN receive frame sequencer: gates raw bits into an external destuffer,
// walks the destuffed fields and checks the unstuffed fixed-form tail.
module can_rx_frame_sequencer
  import can_pkg::*;
#(
  parameter int unsigned IdleBits = DefIdleBits,
  parameter int unsigned EofBits  = DefEofBits,
  parameter int unsigned MaxBytes = DefMaxBytes
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_bit_i,
  input  logic        rx_valid_i,
  output logic        ds_rst_o,
  output logic        ds_bit_in_o,
  output logic        ds_bit_valid_o,
  input  logic        ds_bit_i,
  input  logic        ds_valid_i,
  input  logic        ds_err_i,
  output logic [28:0] rx_id_o,
  output logic        rx_ide_o,
  output logic        rx_rtr_o,
  output logic [3:0]  rx_dlc_o,
  output logic [63:0] rx_data_o,
  output logic [14:0] rx_crc_o,
  output logic        ack_slot_o,
  output logic        frame_ok_o,
  output logic        stuff_err_o,
  output logic        form_err_o,
  output logic        overload_o,
  output logic        busy_o
);

  rx_state_e   state_q, state_d;
  logic [6:0]  cnt_q, cnt_d;
  logic        ds_rst_q, ds_rst_d;
  logic [28:0] id_q, id_d;
  logic        ide_q, ide_d, rtr_q, rtr_d;
  logic [3:0]  dlc_q, dlc_d, dlc_next;
  logic [63:0] data_q, data_d;
  logic [14:0] crc_q, crc_d;
  logic        frame_ok_q, frame_ok_d, stuff_err_q, stuff_err_d;
  logic        form_err_q, form_err_d, overload_q, overload_d;
  logic        stuffed, form_viol, sof_start, stuff_next;
  logic [6:0]  data_len;

  assign dlc_next = {dlc_q[2:0], ds_bit_i};
  assign data_len = data_bits(dlc_clamp(dlc_q, 4'(MaxBytes)));
  assign stuffed  = state_q inside {[StSof:StStuffTail]};

  can_rx_run_tracker u_run_tracker (
    .clk          (clk),
    .rst_n        (rst_n),
    .valid_i      (ds_bit_valid_o),
    .bit_i        (rx_bit_i),
    .start_i      (state_q inside {StWaitSof, StInter}),
    .stuff_next_o (stuff_next)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ds_rst_d    = ds_rst_q;
    id_d        = id_q;
    ide_d       = ide_q;
    rtr_d       = rtr_q;
    dlc_d       = dlc_q;
    data_d      = data_q;
    crc_d       = crc_q;
    frame_ok_d  = 1'b0;
    stuff_err_d = 1'b0;
    form_err_d  = 1'b0;
    overload_d  = 1'b0;
    form_viol   = 1'b0;
    sof_start   = 1'b0;

    ds_bit_valid_o = 1'b0;
    if (state_q inside {[StSof:StCrc]}) begin
      ds_bit_valid_o = rx_valid_i;
    end else if (state_q == StWaitSof) begin
      ds_bit_valid_o = rx_valid_i & ~rx_bit_i;
    end else if (state_q == StStuffTail) begin
      ds_bit_valid_o = rx_valid_i & (cnt_q == 7'd0);
    end else if (state_q == StInter) begin
      ds_bit_valid_o = rx_valid_i & ~rx_bit_i & (cnt_q == 7'd2);
    end

    if (stuffed && ds_err_i) begin
      stuff_err_d = 1'b1;
      ds_rst_d    = 1'b1;
      state_d     = StIdle;
      cnt_d       = 7'd0;
    end else begin
      unique case (state_q)
        StIdle: if (rx_valid_i) begin
          if (!rx_bit_i) begin
            cnt_d = 7'd0;
          end else if (cnt_q == 7'(IdleBits - 1)) begin
            state_d  = StWaitSof;
            cnt_d    = 7'd0;
            ds_rst_d = 1'b0;
          end else begin
            cnt_d = cnt_q + 7'd1;
          end
        end
        StWaitSof: sof_start = rx_valid_i & ~rx_bit_i;
        StSof: if (ds_valid_i) begin
          state_d = StIdA;
          cnt_d   = 7'd0;
        end
        StIdA: if (ds_valid_i) begin
          id_d[5'd28 - cnt_q[4:0]] = ds_bit_i;
          cnt_d = cnt_q + 7'd1;
          if (cnt_q == 7'(IdALen - 1)) begin
            state_d = StSrr;
            cnt_d   = 7'd0;
          end
        end
        StSrr: if (ds_valid_i) begin
          rtr_d   = ds_bit_i;
          state_d = StIde;
        end
        StIde: if (ds_valid_i) begin
          ide_d   = ds_bit_i;
          state_d = ds_bit_i ? StIdB : StR0;
          cnt_d   = 7'd0;
        end
        StIdB: if (ds_valid_i) begin
          id_d[5'd17 - cnt_q[4:0]] = ds_bit_i;
          cnt_d = cnt_q + 7'd1;
          if (cnt_q == 7'(IdBLen - 1)) begin
            state_d = StRtr;
            cnt_d   = 7'd0;
          end
        end
        StRtr: if (ds_valid_i) begin
          rtr_d   = ds_bit_i;
          state_d = StR1;
        end
        StR1: if (ds_valid_i) state_d = StR0;
        StR0: if (ds_valid_i) begin
          state_d = StDlc;
          cnt_d   = 7'd0;
        end
        StDlc: if (ds_valid_i) begin
          dlc_d = dlc_next;
          cnt_d = cnt_q + 7'd1;
          if (cnt_q == 7'(DlcLen - 1)) begin
            cnt_d   = 7'd0;
            state_d = (rtr_q || (dlc_next == 4'd0)) ? StCrc : StData;
          end
        end
        StData: if (ds_valid_i) begin
          data_d[6'd63 - cnt_q[5:0]] = ds_bit_i;
          cnt_d = cnt_q + 7'd1;
          if (cnt_q == data_len - 7'd1) begin
            state_d = StCrc;
            cnt_d   = 7'd0;
          end
        end
        StCrc: if (ds_valid_i) begin
          crc_d = {crc_q[13:0], ds_bit_i};
          cnt_d = cnt_q + 7'd1;
          if (cnt_q == 7'(CrcLen - 1)) begin
            cnt_d = 7'd0;
            if (stuff_next) begin
              state_d = StStuffTail;
            end else begin
              state_d  = StCrcDel;
              ds_rst_d = 1'b1;
            end
          end
        end
        // cnt 0: forward the trailing stuff bit; cnt 1: its destuffer result slot.
        StStuffTail: if (cnt_q == 7'd0) begin
          if (rx_valid_i) cnt_d = 7'd1;
        end else begin
          state_d  = StCrcDel;
          cnt_d    = 7'd0;
          ds_rst_d = 1'b1;
        end
        StCrcDel: if (rx_valid_i) begin
          if (!rx_bit_i) form_viol = 1'b1;
          else state_d = StAckSlot;
        end
        StAckSlot: if (rx_valid_i) state_d = StAckDel;
        StAckDel: if (rx_valid_i) begin
          if (!rx_bit_i) form_viol = 1'b1;
          else begin
            state_d = StEof;
            cnt_d   = 7'd0;
          end
        end
        StEof: if (rx_valid_i) begin
          if (cnt_q == 7'(EofBits - 1)) begin
            frame_ok_d = 1'b1;
            state_d    = StInter;
            cnt_d      = 7'd0;
          end else if (!rx_bit_i) begin
            form_viol = 1'b1;
          end else begin
            cnt_d = cnt_q + 7'd1;
          end
        end
        StInter: if (rx_valid_i) begin
          if (!rx_bit_i) begin
            if (cnt_q == 7'd2) begin
              sof_start = 1'b1;
            end else begin
              overload_d = 1'b1;
              state_d    = StIdle;
              cnt_d      = 7'd0;
            end
          end else if (cnt_q == 7'd2) begin
            state_d = StWaitSof;
            cnt_d   = 7'd0;
          end else begin
            // Release the destuffer ahead of bit 3, which may be a SOF.
            if (cnt_q == 7'd1) ds_rst_d = 1'b0;
            cnt_d = cnt_q + 7'd1;
          end
        end
        default: state_d = StIdle;
      endcase
    end

    if (form_viol) begin
      form_err_d = 1'b1;
      ds_rst_d   = 1'b1;
      state_d    = StIdle;
      cnt_d      = 7'd0;
    end
    if (sof_start) begin
      state_d = StSof;
      cnt_d   = 7'd0;
      id_d    = '0;
      ide_d   = 1'b0;
      rtr_d   = 1'b0;
      dlc_d   = '0;
      data_d  = '0;
      crc_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      ds_rst_q    <= 1'b1;
      id_q        <= '0;
      ide_q       <= 1'b0;
      rtr_q       <= 1'b0;
      dlc_q       <= '0;
      data_q      <= '0;
      crc_q       <= '0;
      frame_ok_q  <= 1'b0;
      stuff_err_q <= 1'b0;
      form_err_q  <= 1'b0;
      overload_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ds_rst_q    <= ds_rst_d;
      id_q        <= id_d;
      ide_q       <= ide_d;
      rtr_q       <= rtr_d;
      dlc_q       <= dlc_d;
      data_q      <= data_d;
      crc_q       <= crc_d;
      frame_ok_q  <= frame_ok_d;
      stuff_err_q <= stuff_err_d;
      form_err_q  <= form_err_d;
      overload_q  <= overload_d;
    end
  end

  assign ds_rst_o    = ds_rst_q;
  assign ds_bit_in_o = rx_bit_i;
  assign rx_id_o     = id_q;
  assign rx_ide_o    = ide_q;
  assign rx_rtr_o    = rtr_q;
  assign rx_dlc_o    = dlc_q;
  assign rx_data_o   = data_q;
  assign rx_crc_o    = crc_q;
  assign ack_slot_o  = (state_q == StAckSlot);
  assign frame_ok_o  = frame_ok_q;
  assign stuff_err_o = stuff_err_q;
  assign form_err_o  = form_err_q;
  assign overload_o  = overload_q;
  assign busy_o      = !(state_q inside {StIdle, StWaitSof});

endmodule

// File: tb/tb_can_rx_frame_sequencer.sv
// Directed bench for can_rx_frame_sequencer with a behavioural bit destuffer.
module tb_can_rx_frame_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_bit = 1'b1;
  logic        rx_valid = 1'b0;
  logic        ds_rst, ds_bit_in, ds_bit_valid;
  logic        ds_bit, ds_valid, ds_err;
  logic [28:0] rx_id;
  logic        rx_ide, rx_rtr;
  logic [3:0]  rx_dlc;
  logic [63:0] rx_data;
  logic [14:0] rx_crc;
  logic        ack_slot, frame_ok, stuff_err, form_err, overload, busy;

  int checks = 0;
  int failures = 0;
  int n_ok = 0, n_stuff = 0, n_form = 0, n_ovl = 0, n_ack = 0;
  bit raw[$];

  always #5 clk = ~clk;

  can_rx_frame_sequencer dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rx_bit_i       (rx_bit),
    .rx_valid_i     (rx_valid),
    .ds_rst_o       (ds_rst),
    .ds_bit_in_o    (ds_bit_in),
    .ds_bit_valid_o (ds_bit_valid),
    .ds_bit_i       (ds_bit),
    .ds_valid_i     (ds_valid),
    .ds_err_i       (ds_err),
    .rx_id_o        (rx_id),
    .rx_ide_o       (rx_ide),
    .rx_rtr_o       (rx_rtr),
    .rx_dlc_o       (rx_dlc),
    .rx_data_o      (rx_data),
    .rx_crc_o       (rx_crc),
    .ack_slot_o     (ack_slot),
    .frame_ok_o     (frame_ok),
    .stuff_err_o    (stuff_err),
    .form_err_o     (form_err),
    .overload_o     (overload),
    .busy_o         (busy)
  );

  // Destuffer stand-in: drops the bit after five equal bits, errors if it is not inverted.
  logic [2:0] dsm_run;
  logic       dsm_last;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ds_valid <= 1'b0;
      ds_err   <= 1'b0;
      ds_bit   <= 1'b0;
      dsm_run  <= 3'd0;
      dsm_last <= 1'b1;
    end else begin
      ds_valid <= 1'b0;
      ds_err   <= 1'b0;
      if (ds_rst) begin
        dsm_run <= 3'd0;
      end else if (ds_bit_valid) begin
        dsm_last <= ds_bit_in;
        if (dsm_run == 3'd5) begin
          dsm_run <= 3'd1;
          if (ds_bit_in == dsm_last) ds_err <= 1'b1;
        end else begin
          ds_valid <= 1'b1;
          ds_bit   <= ds_bit_in;
          dsm_run  <= (dsm_run == 3'd0 || ds_bit_in != dsm_last) ? 3'd1 : dsm_run + 3'd1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (frame_ok) n_ok++;
    if (stuff_err) n_stuff++;
    if (form_err) n_form++;
    if (overload) n_ovl++;
    if (ack_slot) n_ack++;
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic send_bit(input bit b);
    @(negedge clk);
    rx_bit   = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic send_n(input bit b, input int n);
    for (int i = 0; i < n; i++) send_bit(b);
  endtask

  task automatic send_raw(input int n);
    for (int i = 0; i < n && i < raw.size(); i++) send_bit(raw[i]);
  endtask

  // CRC delimiter, ACK (dominant from another node), ACK delimiter, EOF.
  task automatic send_tail(input bit crc_del);
    send_bit(crc_del);
    send_bit(1'b0);
    send_bit(1'b1);
    send_n(1'b1, 7);
  endtask

  task automatic build_frame(input bit ide, input logic [28:0] id, input bit rtr,
                             input logic [3:0] dlc, input logic [63:0] data,
                             input logic [14:0] crc);
    bit u[$];
    int nbits;
    int run;
    bit last;
    u.push_back(1'b0);
    for (int i = 28; i >= 18; i--) u.push_back(id[i]);
    if (!ide) begin
      u.push_back(rtr); u.push_back(1'b0); u.push_back(1'b0);
    end else begin
      u.push_back(1'b1); u.push_back(1'b1);
      for (int i = 17; i >= 0; i--) u.push_back(id[i]);
      u.push_back(rtr); u.push_back(1'b0); u.push_back(1'b0);
    end
    for (int i = 3; i >= 0; i--) u.push_back(dlc[i]);
    nbits = rtr ? 0 : ((dlc > 4'd8) ? 64 : int'(dlc) * 8);
    for (int i = 0; i < nbits; i++) u.push_back(data[63-i]);
    for (int i = 14; i >= 0; i--) u.push_back(crc[i]);
    raw.delete();
    run  = 0;
    last = 1'b0;
    foreach (u[i]) begin
      raw.push_back(u[i]);
      run  = (run > 0 && u[i] == last) ? run + 1 : 1;
      last = u[i];
      if (run == 5) begin
        raw.push_back(!last);
        last = !last;
        run  = 1;
      end
    end
  endtask

  task automatic check_frame(input string tag, input logic [28:0] id, input bit ide, input bit rtr,
                             input logic [3:0] dlc, input logic [63:0] data,
                             input logic [14:0] crc);
    check_val({tag, "_id"}, rx_id, id);
    check_val({tag, "_ide"}, rx_ide, ide);
    check_val({tag, "_rtr"}, rx_rtr, rtr);
    check_val({tag, "_dlc"}, rx_dlc, dlc);
    check_val({tag, "_data"}, rx_data, data);
    check_val({tag, "_crc"}, rx_crc, crc);
  endtask

  initial begin
    int ok0, a0, st0, fo0, ov0;

    repeat (2) @(negedge clk);
    check_val("rst_ds_rst", ds_rst, 1'b1);
    check_val("rst_busy", busy, 1'b0);
    check_val("rst_id", rx_id, 0);
    check_val("rst_data", rx_data, 0);
    check_val("rst_ack", ack_slot, 1'b0);
    check_val("rst_ok", frame_ok, 1'b0);
    rst_n = 1'b1;

    // Standard data frame.
    ok0 = n_ok; a0 = n_ack;
    build_frame(1'b0, {11'h123, 18'h0}, 1'b0, 4'd2, 64'hA53C_0000_0000_0000, 15'h4321);
    send_n(1'b1, 11);
    send_raw(raw.size());
    check_val("std_busy", busy, 1'b1);
    send_tail(1'b1);
    send_n(1'b1, 3);
    check_val("std_ok", n_ok - ok0, 1);
    check_val("std_ack_cycles", n_ack - a0, 5);
    check_val("std_idle_busy", busy, 1'b0);
    check_frame("std", {11'h123, 18'h0}, 1'b0, 1'b0, 4'd2, 64'hA53C_0000_0000_0000, 15'h4321);

    // Extended remote frame: no data bits despite DLC=4.
    ok0 = n_ok;
    build_frame(1'b1, 29'h1ABC_DEF0, 1'b1, 4'd4, 64'hFFFF_FFFF_0000_0000, 15'h1A5A);
    send_n(1'b1, 11);
    send_raw(raw.size());
    send_tail(1'b1);
    send_n(1'b1, 3);
    check_val("ext_ok", n_ok - ok0, 1);
    check_frame("ext", 29'h1ABC_DEF0, 1'b1, 1'b1, 4'd4, 64'h0, 15'h1A5A);

    // CRC ending 0,0,1,1,1,1,1 needs a trailing stuff bit.
    ok0 = n_ok; st0 = n_stuff;
    build_frame(1'b0, {11'h321, 18'h0}, 1'b0, 4'd1, 64'h5A00_0000_0000_0000, 15'h2A9F);
    send_n(1'b1, 11);
    send_raw(raw.size());
    send_tail(1'b1);
    send_n(1'b1, 3);
    check_val("tail_ok", n_ok - ok0, 1);
    check_val("tail_no_stuff_err", n_stuff - st0, 0);
    check_val("tail_crc", rx_crc, 15'h2A9F);

    // Same frame with the trailing stuff bit corrupted.
    ok0 = n_ok; st0 = n_stuff;
    raw[raw.size()-1] = !raw[raw.size()-1];
    send_n(1'b1, 11);
    send_raw(raw.size());
    check_val("badtail_stuff_err", n_stuff - st0, 1);
    check_val("badtail_busy", busy, 1'b0);
    send_tail(1'b1);
    send_n(1'b1, 3);
    check_val("badtail_no_ok", n_ok - ok0, 0);

    // Dominant CRC delimiter.
    ok0 = n_ok; fo0 = n_form;
    build_frame(1'b0, {11'h0AA, 18'h0}, 1'b0, 4'd1, 64'hC300_0000_0000_0000, 15'h0F0F);
    send_n(1'b1, 11);
    send_raw(raw.size());
    send_bit(1'b0);
    check_val("crcdel_form_err", n_form - fo0, 1);
    check_val("crcdel_ds_rst", ds_rst, 1'b1);
    check_val("crcdel_busy", busy, 1'b0);
    send_bit(1'b0);
    send_n(1'b1, 11);
    check_val("crcdel_no_ok", n_ok - ok0, 0);

    // Overload: dominant in intermission bit 2.
    ok0 = n_ok; ov0 = n_ovl;
    build_frame(1'b0, {11'h2AA, 18'h0}, 1'b0, 4'd1, 64'h8100_0000_0000_0000, 15'h1111);
    send_n(1'b1, 11);
    send_raw(raw.size());
    send_tail(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    check_val("ovl_pulse", n_ovl - ov0, 1);
    check_val("ovl_ok", n_ok - ok0, 1);
    check_val("ovl_busy", busy, 1'b0);

    // Dominant intermission bit 3 is the SOF of a back-to-back frame.
    ok0 = n_ok; ov0 = n_ovl;
    send_n(1'b1, 11);
    send_raw(raw.size());
    send_tail(1'b1);
    send_n(1'b1, 2);
    build_frame(1'b0, {11'h0F0, 18'h0}, 1'b0, 4'd1, 64'h7E00_0000_0000_0000, 15'h1234);
    send_raw(raw.size());
    send_tail(1'b1);
    send_n(1'b1, 3);
    check_val("b2b_ok", n_ok - ok0, 2);
    check_val("b2b_no_ovl", n_ovl - ov0, 0);
    check_frame("b2b", {11'h0F0, 18'h0}, 1'b0, 1'b0, 4'd1, 64'h7E00_0000_0000_0000, 15'h1234);

    // DLC=15 clamps to 8 bytes.
    ok0 = n_ok;
    build_frame(1'b0, {11'h456, 18'h0}, 1'b0, 4'd15, 64'h0123_4567_89AB_CDEF, 15'h7001);
    send_n(1'b1, 11);
    send_raw(raw.size());
    send_tail(1'b1);
    send_n(1'b1, 3);
    check_val("dlc15_ok", n_ok - ok0, 1);
    check_frame("dlc15", {11'h456, 18'h0}, 1'b0, 1'b0, 4'd15, 64'h0123_4567_89AB_CDEF, 15'h7001);

    // Reset in the middle of the data field.
    ok0 = n_ok;
    build_frame(1'b0, {11'h3C3, 18'h0}, 1'b0, 4'd15, 64'hF0F0_F0F0_F0F0_F0F0, 15'h0101);
    send_n(1'b1, 11);
    send_raw(40);
    check_val("mid_dlc", rx_dlc, 4'd15);
    check_val("mid_busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check_val("mrst_ds_rst", ds_rst, 1'b1);
    check_val("mrst_busy", busy, 1'b0);
    check_frame("mrst", 29'h0, 1'b0, 1'b0, 4'd0, 64'h0, 15'h0);
    check_val("mrst_ack", ack_slot, 1'b0);
    check_val("mrst_ok", frame_ok, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    send_n(1'b1, 12);
    check_val("mrst_no_ok", n_ok - ok0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
